// File: rtl/bf_run_controller.sv
// Program lifecycle sequencer for a brainfuck core: load code, clear array RAM, run, done.
// Optional RUN-cycle counter enabled by defining BF_CYCLE_COUNT_EN.
module bf_run_controller #(
    parameter int addrSize_array = 9,
    parameter int addrSize_code  = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      code_we,
    output logic [addrSize_code-1:0]  code_addr,
    output logic [7:0]                code_wdata,
    input  logic [addrSize_code-1:0]  core_addr_code,
    output logic                      array_we,
    output logic [addrSize_array-1:0] array_addr,
    output logic [7:0]                array_wdata,
    input  logic [addrSize_array-1:0] core_addr_array,
    input  logic [7:0]                core_dataOut_array,
    input  logic                      core_writeRq_array,
    output logic                      core_reset_n,
    input  logic                      core_done,
    output logic                      busy,
    output logic                      finished,
    output logic                      overflow,
    output logic [31:0]               run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [addrSize_code-1:0]  CODE_LAST  = {addrSize_code{1'b1}};
    localparam logic [addrSize_code-1:0]  CODE_ONE   = {{(addrSize_code-1){1'b0}}, 1'b1};
    localparam logic [addrSize_array-1:0] ARRAY_LAST = {addrSize_array{1'b1}};
    localparam logic [addrSize_array-1:0] ARRAY_ONE  = {{(addrSize_array-1){1'b0}}, 1'b1};

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [addrSize_code-1:0]    load_ptr_r;
    logic [addrSize_array-1:0]   clear_ptr_r;
    logic                        overflow_r;
    logic                        load_entry_s;
    logic                        code_full_s;

    assign load_entry_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign code_full_s  = (load_ptr_r == CODE_LAST);
    assign overflow     = overflow_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load pointer, clear pointer and truncation flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ptr_r  <= {addrSize_code{1'b0}};
            clear_ptr_r <= {addrSize_array{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_ptr_r <= {addrSize_code{1'b0}};
                        overflow_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        clear_ptr_r <= {addrSize_array{1'b0}};
                        // Pointer stops at the last address; a byte arriving there ends the load.
                        if (code_full_s) begin
                            overflow_r <= (rx_data != 8'h00);
                        end else begin
                            load_ptr_r <= load_ptr_r + CODE_ONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    clear_ptr_r <= clear_ptr_r + ARRAY_ONE;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BF_CYCLE_COUNT_EN
    logic [31:0] run_cnt_r;

    // Saturating RUN-cycle counter, cleared on each new load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_r <= 32'd0;
        end else if (load_entry_s) begin
            run_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && (run_cnt_r != 32'hFFFF_FFFF)) begin
            run_cnt_r <= run_cnt_r + 32'd1;
        end
    end

    assign run_cycles = run_cnt_r;
`else
    assign run_cycles = 32'd0;
`endif

    // Next-state logic and RAM port muxing
    always_comb begin
        state_nxt_s  = state_r;
        code_we      = 1'b0;
        code_addr    = load_ptr_r;
        code_wdata   = 8'h00;
        array_we     = 1'b0;
        array_addr   = {addrSize_array{1'b0}};
        array_wdata  = 8'h00;
        core_reset_n = 1'b0;
        busy         = 1'b0;
        finished     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                code_we    = rx_valid;
                code_addr  = load_ptr_r;
                code_wdata = code_full_s ? 8'h00 : rx_data;
                if (rx_valid && (code_full_s || (rx_data == 8'h00))) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                busy        = 1'b1;
                array_we    = 1'b1;
                array_addr  = clear_ptr_r;
                array_wdata = 8'h00;
                if (clear_ptr_r == ARRAY_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                busy         = 1'b1;
                core_reset_n = 1'b1;
                code_addr    = core_addr_code;
                array_we     = core_writeRq_array;
                array_addr   = core_addr_array;
                array_wdata  = core_dataOut_array;
                if (core_done) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                finished     = 1'b1;
                core_reset_n = 1'b1;
                code_addr    = core_addr_code;
                array_we     = core_writeRq_array;
                array_addr   = core_addr_array;
                array_wdata  = core_dataOut_array;
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bf_run_controller.sv
// Directed, table-driven bench for bf_run_controller: load, clear, run, done, overflow, restart, async reset.
module tb_bf_run_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        code_we;
    logic [8:0]  code_addr;
    logic [7:0]  code_wdata;
    logic [8:0]  core_addr_code;
    logic        array_we;
    logic [8:0]  array_addr;
    logic [7:0]  array_wdata;
    logic [8:0]  core_addr_array;
    logic [7:0]  core_dataOut_array;
    logic        core_writeRq_array;
    logic        core_reset_n;
    logic        core_done;
    logic        busy;
    logic        finished;
    logic        overflow;
    logic [31:0] run_cycles;

    int checks = 0;
    int errors = 0;

    bf_run_controller #(.addrSize_array(9), .addrSize_code(9)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .code_we(code_we), .code_addr(code_addr), .code_wdata(code_wdata),
        .core_addr_code(core_addr_code), .array_we(array_we), .array_addr(array_addr),
        .array_wdata(array_wdata), .core_addr_array(core_addr_array),
        .core_dataOut_array(core_dataOut_array), .core_writeRq_array(core_writeRq_array),
        .core_reset_n(core_reset_n), .core_done(core_done), .busy(busy),
        .finished(finished), .overflow(overflow), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       rv;
        logic [7:0] rd;
        logic       chk_code;
        logic       e_cwe;
        logic [8:0] e_caddr;
        logic [7:0] e_cwd;
        logic       e_busy;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [31:0] exp_rc(input int n);
`ifdef BF_CYCLE_COUNT_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Walks the 512 clear cycles; at cycle ign_at the host pulses start and rx_valid.
    task automatic do_clear(input int ign_at);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            start    = (i == ign_at);
            rx_valid = (i == ign_at);
            rx_data  = 8'h5A;
            #1;
            if (array_we !== 1'b1 || array_addr !== 9'(i) || array_wdata !== 8'h00 ||
                code_we !== 1'b0 || core_reset_n !== 1'b0 || busy !== 1'b1 || finished !== 1'b0)
                bad++;
            cyc();
        end
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("clear_cycles_bad", 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        core_addr_code = 9'h0A5; core_addr_array = 9'h123; core_dataOut_array = 8'hC3;
        core_writeRq_array = 1'b1; core_done = 1'b0;

        //            st    rv    rd     chk   cwe   caddr  cwd    busy
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 9'd0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h2B, 1'b1, 1'b1, 9'd0, 8'h2B, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h2E, 1'b1, 1'b1, 9'd1, 8'h2E, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 9'd2, 8'h77, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 9'd2, 8'h00, 1'b1};

        #12;
        chk("rst_code_we", 32'(code_we), 32'd0);
        chk("rst_array_we", 32'(array_we), 32'd0);
        chk("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        reset = 1'b1;
        cyc();

        // Program 1: IDLE, start with a dropped byte, then 0x2B 0x2E 0x00
        for (int v = 0; v < 7; v++) begin
            start = tbl[v].st; rx_valid = tbl[v].rv; rx_data = tbl[v].rd;
            #1;
            chk($sformatf("v%0d_code_we", v), 32'(code_we), 32'(tbl[v].e_cwe));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(tbl[v].e_busy));
            chk($sformatf("v%0d_core_reset_n", v), 32'(core_reset_n), 32'd0);
            chk($sformatf("v%0d_array_we", v), 32'(array_we), 32'd0);
            if (tbl[v].chk_code) begin
                chk($sformatf("v%0d_code_addr", v), 32'(code_addr), 32'(tbl[v].e_caddr));
                chk($sformatf("v%0d_code_wdata", v), 32'(code_wdata), 32'(tbl[v].e_cwd));
            end
            cyc();
        end
        start = 1'b0; rx_valid = 1'b0;

        do_clear(100);

        // RUN: done raised in the 20th RUN cycle, host noise in cycle 3
        for (int k = 0; k < 20; k++) begin
            core_done = (k == 19);
            start     = (k == 3);
            rx_valid  = (k == 3);
            #1;
            if (k == 0) begin
                chk("run_core_reset_n", 32'(core_reset_n), 32'd1);
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_code_addr", 32'(code_addr), 32'h0A5);
                chk("run_array_addr", 32'(array_addr), 32'h123);
                chk("run_array_wdata", 32'(array_wdata), 32'hC3);
                chk("run_array_we", 32'(array_we), 32'd1);
            end
            if (k == 3) begin
                chk("run_ignore_code_we", 32'(code_we), 32'd0);
                chk("run_ignore_finished", 32'(finished), 32'd0);
            end
            if (k == 10) chk("run_cycles_mid", run_cycles, exp_rc(10));
            cyc();
        end
        core_done = 1'b0; start = 1'b0; rx_valid = 1'b0;
        core_writeRq_array = 1'b0;
        #1;
        chk("done_finished", 32'(finished), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_core_reset_n", 32'(core_reset_n), 32'd1);
        chk("done_run_cycles", run_cycles, exp_rc(20));
        chk("done_array_we_follows_core", 32'(array_we), 32'd0);
        cyc(); cyc(); cyc();
        chk("done_frozen_run_cycles", run_cycles, exp_rc(20));
        chk("done_hold_finished", 32'(finished), 32'd1);

        // Restart into an overflowing program
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("restart1_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("restart1_busy", 32'(busy), 32'd1);
        chk("restart1_run_cycles", run_cycles, 32'd0);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h80 | 8'(i & 127);
            #1;
            if (code_we !== 1'b1 || code_addr !== 9'(i) ||
                code_wdata !== ((i == 511) ? 8'h00 : (8'h80 | 8'(i & 127))))
                bad++;
            if (i == 510) chk("ovf_before_last", 32'(overflow), 32'd0);
            if (i == 511) chk("ovf_last_wdata", 32'(code_wdata), 32'h00);
            cyc();
        end
        rx_valid = 1'b0;
        chk("ovf_load_bad", 32'(bad), 32'd0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        do_clear(0);
        chk("ovf_flag_after_clear", 32'(overflow), 32'd1);

        core_done = 1'b1;
        #1;
        chk("run2_core_reset_n", 32'(core_reset_n), 32'd1);
        cyc();
        core_done = 1'b0;
        #1;
        chk("run2_finished", 32'(finished), 32'd1);
        chk("run2_run_cycles", run_cycles, exp_rc(1));

        // Restart clears overflow and counter; new program from address 0
        start = 1'b1;
        #1;
        chk("done_start_core_reset_n", 32'(core_reset_n), 32'd1);
        cyc();
        start = 1'b0;
        #1;
        chk("restart2_overflow", 32'(overflow), 32'd0);
        chk("restart2_run_cycles", run_cycles, 32'd0);
        chk("restart2_core_reset_n", 32'(core_reset_n), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h11 + 8'(i);
            #1;
            if (i == 0) chk("restart2_first_addr", 32'(code_addr), 32'd0);
            cyc();
        end
        #1;
        chk("preload_ptr5_addr", 32'(code_addr), 32'd5);
        chk("preload_ptr5_code_we", 32'(code_we), 32'd1);

        // Asynchronous reset mid-LOAD, checked before the next clock edge
        #1;
        reset = 1'b0;
        #1;
        chk("areset_code_we", 32'(code_we), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("areset_finished", 32'(finished), 32'd0);
        chk("areset_array_we", 32'(array_we), 32'd0);
        chk("areset_run_cycles", run_cycles, 32'd0);
        rx_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset_busy", 32'(busy), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h3E;
        #1;
        chk("post_reset_load_addr", 32'(code_addr), 32'd0);
        chk("post_reset_load_we", 32'(code_we), 32'd1);
        rx_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_run_controller.md
Name: bf_run_controller

Overview:
Sequences one brainfuckCore-style processor through a program lifecycle: load, clear, run, done.
- Loads a program byte stream (from the UART receiver) into the code RAM.
- Zeroes the array RAM.
- Releases the core from reset and watches its done flag.
- Owns the write/address muxes of both RAMs, sharing them between the loader/clearer and the core.

Parameters:
addrSize_array, 9, array RAM address width (depth 2^addrSize_array)
addrSize_code, 9, code RAM address width (depth 2^addrSize_code)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse: begin load of a new program
rx_valid  in  1  program byte valid strobe (1 cycle per byte)
rx_data  in  8  program byte
code_we  out  1  code RAM write enable
code_addr  out  addrSize_code  code RAM address (muxed)
code_wdata  out  8  code RAM write data
core_addr_code  in  addrSize_code  core's code address
array_we  out  1  array RAM write enable (muxed)
array_addr  out  addrSize_array  array RAM address (muxed)
array_wdata  out  8  array RAM write data (muxed)
core_addr_array  in  addrSize_array  core's array address
core_dataOut_array  in  8  core's array write data
core_writeRq_array  in  1  core's array write request
core_reset_n  out  1  drives core reset input (active-low)
core_done  in  1  core done flag
busy  out  1  high in LOAD, CLEAR, RUN
finished  out  1  high in DONE
overflow  out  1  last load truncated
run_cycles  out  32  RUN-state cycle count (see Optional Feature)

Behaviour:
- Reset (async, reset=0): state=IDLE; load_ptr=0, clear_ptr=0, overflow=0, run_cycles=0.
  - Outputs: code_we=0, array_we=0, core_reset_n=0, busy=0, finished=0.
- States: IDLE, LOAD, CLEAR, RUN, DONE. Encoded registered; outputs decoded combinationally from state and counters.
- IDLE:
  - core_reset_n=0.
  - start=1 -> LOAD, load_ptr=0, overflow=0.
- LOAD:
  - code_addr=load_ptr, code_wdata=rx_data, code_we=rx_valid.
  - Each rx_valid: write, then load_ptr+1.
  - rx_valid with rx_data=0x00: write it, -> CLEAR next cycle, clear_ptr=0.
  - rx_valid at load_ptr=2^addrSize_code-1: code_wdata forced 0x00. overflow=1 if rx_data!=0. -> CLEAR.
  - load_ptr never wraps.
  - start ignored.
- CLEAR:
  - array_we=1, array_addr=clear_ptr, array_wdata=0.
  - clear_ptr+1 each cycle.
  - After writing 2^addrSize_array-1 -> RUN. Exactly 2^addrSize_array cycles.
  - rx_valid and start ignored.
- RUN:
  - core_reset_n=1 from first RUN cycle.
  - code_addr=core_addr_code, code_we=0.
  - Array port follows core: array_addr=core_addr_array, array_wdata=core_dataOut_array, array_we=core_writeRq_array.
  - core_done=1 -> DONE next edge.
  - start and rx_valid ignored.
- DONE:
  - core_reset_n stays 1; core holds its halted state; array port still muxed to core (host may read results).
  - finished=1.
  - start=1 -> LOAD, core_reset_n=0 from that LOAD cycle.
- Outside RUN/DONE the core sees no RAM writes: array mux selects the clearer or idle (array_we=0).
- Outside LOAD, code_we=0.
- Reset mid-operation: immediate return to IDLE. RAM contents undefined; a new start reloads.
- Simultaneous start and rx_valid in IDLE: start is taken; that byte is dropped.

Optional Feature:
BF_CYCLE_COUNT_EN
- Defined: 32-bit run_cycles.
  - Cleared on entry to LOAD.
  - Increments every RUN cycle; saturates at 0xFFFFFFFF.
  - Frozen in DONE.
- Undefined: run_cycles tied to 0, no counter logic.

Test Plan:
- Load: start, bytes 0x2B,0x2E,0x00 -> code writes addr0=0x2B, addr1=0x2E, addr2=0x00. Then 512 array_we cycles (addr 0..511, data 0). Then core_reset_n=1.
- Run: core_done asserted 20 cycles after RUN entry -> finished=1, busy=0. run_cycles=20 with BF_CYCLE_COUNT_EN.
- Overflow: 512 nonzero bytes -> addr511 written 0x00, overflow=1, CLEAR entered. 513th byte not written.
- Ignore: start pulsed and rx_valid=1 in CLEAR and RUN -> no state change, code_we=0, core_reset_n unchanged.
- Restart: start in DONE -> core_reset_n=0, overflow=0, run_cycles=0. New program loads from addr0.
- Reset: reset=0 mid-LOAD (load_ptr=5) -> IDLE and all outputs at reset values asynchronously, before next clk edge.
